// File: rtl/sram_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sram_controller                                            |
// | Description : Splits each 32-bit load/store from the memory stage into   |
// |               two 16-bit accesses to an off-chip asynchronous SRAM (low  |
// |               half first, then high half). Each half is held for         |
// |               WAIT_CYCLES+1 cycles. `ready` low freezes the pipeline.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Parameters:                                                              |
// |   WAIT_CYCLES  extra cycles each half-access is held (0..15)             |
// |   BASE_ADDR    byte address mapped to SRAM word 0                        |
// | Ports:                                                                   |
// |   clk          clock, rising edge                                        |
// |   rst          synchronous active-low reset                              |
// |   wr_en/rd_en  store / load request (level, write wins if both)          |
// |   addr         32-bit byte address                                       |
// |   wr_data      32-bit store data                                         |
// |   rd_data      last completed load word                                  |
// |   ready        high = no access pending                                  |
// |   sram_addr    18-bit SRAM halfword address                              |
// |   sram_dq_out  write data driven onto the SRAM bus                       |
// |   sram_dq_oe   high = controller drives sram_dq_out                      |
// |   sram_dq_in   read data from the SRAM bus                               |
// |   sram_we_n    SRAM write enable, active-low                             |
// | Build option:                                                            |
// |   SRAM_RANGE_CHECK_EN  when defined, requests outside                    |
// |                        [BASE_ADDR, BASE_ADDR+2^19) are ignored           |
// +--------------------------------------------------------------------------+
module sram_controller #(
   parameter int WAIT_CYCLES = 1,
   parameter int BASE_ADDR   = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] addr,
   input  logic [31:0] wr_data,
   output logic [31:0] rd_data,
   output logic        ready,
   output logic [17:0] sram_addr,
   output logic [15:0] sram_dq_out,
   output logic        sram_dq_oe,
   input  logic [15:0] sram_dq_in,
   output logic        sram_we_n
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES);
   localparam logic [31:0] BASE      = 32'(BASE_ADDR);

   state_t      state;
   state_t      state_nxt;
   logic [3:0]  cnt;
   logic [3:0]  cnt_nxt;
   logic        accept;
   logic        lo_last;
   logic        hi_last;
   logic        active;

   logic        op_wr;
   logic [16:0] word;
   logic [15:0] data_hi;

   logic [31:0] offset;
   logic        in_range;
   logic        unused_bits;

   // Byte offset from the SRAM window; bits [18:2] are the word index
   // modulo 2^17, so out-of-window addresses wrap naturally.
   assign offset = addr - BASE;

`ifdef SRAM_RANGE_CHECK_EN
   assign in_range = (offset[31:19] == 13'd0);
`else
   assign in_range = 1'b1;
`endif

   assign unused_bits = ^{offset[31:19], offset[1:0]};

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next state and SRAM strobes
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      lo_last   = 1'b0;
      hi_last   = 1'b0;
      case (state)
         IDLE: begin
            if ((wr_en || rd_en) && in_range) begin
               accept    = 1'b1;
               state_nxt = LO;
               cnt_nxt   = 4'd0;
            end
         end
         LO: begin
            if (cnt == WAIT_LAST) begin
               lo_last   = 1'b1;
               state_nxt = HI;
               cnt_nxt   = 4'd0;
            end else begin
               cnt_nxt = cnt + 4'd1;
            end
         end
         HI: begin
            if (cnt == WAIT_LAST) begin
               hi_last   = 1'b1;
               state_nxt = DONE;
               cnt_nxt   = 4'd0;
            end else begin
               cnt_nxt = cnt + 4'd1;
            end
         end
         DONE: begin
            // Always returns to IDLE so a held request sees one ready cycle.
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      active     = (state == LO) || (state == HI);
      sram_dq_oe = active && op_wr;
      sram_we_n  = !(active && op_wr);
      // An ignored out-of-range request leaves ready high.
      ready      = ((state == IDLE) && !accept) || (state == DONE);
   end

   // Latched request, SRAM address/data and load result
   always_ff @(posedge clk) begin
      if (!rst) begin
         op_wr       <= 1'b0;
         word        <= 17'd0;
         data_hi     <= 16'd0;
         sram_addr   <= 18'd0;
         sram_dq_out <= 16'd0;
         rd_data     <= 32'd0;
      end else begin
         if (accept) begin
            op_wr     <= wr_en;
            word      <= offset[18:2];
            data_hi   <= wr_data[31:16];
            sram_addr <= {offset[18:2], 1'b0};
            if (wr_en) begin
               sram_dq_out <= wr_data[15:0];
            end
         end
         if (lo_last) begin
            sram_addr <= {word, 1'b1};
            if (op_wr) begin
               sram_dq_out <= data_hi;
            end else begin
               rd_data[15:0] <= sram_dq_in;
            end
         end
         if (hi_last && !op_wr) begin
            rd_data[31:16] <= sram_dq_in;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/sram_controller.md
# sram_controller

Multi-cycle controller between the memory stage and an off-chip 16-bit asynchronous SRAM. Each 32-bit load/store from the memory stage is split into two 16-bit SRAM transactions (low half, then high half), each with a configurable wait-state count. `ready` is low while a transaction is in flight and drives the pipeline freeze; the memory stage holds its request stable until `ready` returns high.

## Interface
- `WAIT_CYCLES`, 1: extra cycles each half-access is held, in addition to its first cycle; legal range 0–15.
- `BASE_ADDR`, 1024: byte address mapped to SRAM word 0.

Ports:
- `clk`  in  1  sole clock; everything updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-low; sampled on the rising edge of `clk`.
- `wr_en`  in  1  store request (level).
- `rd_en`  in  1  load request (level).
- `addr`  in  32  byte address from the memory stage.
- `wr_data`  in  32  store data.
- `rd_data`  out  32  last completed load word.
- `ready`  out  1  high = no access pending; low = freeze the pipeline.
- `sram_addr`  out  18  SRAM halfword address.
- `sram_dq_out`  out  16  write data driven onto the SRAM bus.
- `sram_dq_oe`  out  1  high = controller drives `sram_dq_out`.
- `sram_dq_in`  in  16  read data from the SRAM bus.
- `sram_we_n`  out  1  SRAM write enable, active-low.

## Operation
- Address mapping:
  - Word index `w = (addr - BASE_ADDR) >> 2`, taken modulo 2^17.
  - `sram_addr = {w[16:0], h}`, where h=0 for the low half and h=1 for the high half.
- FSM states: IDLE, LO, HI, DONE.
- IDLE:
  - If `wr_en | rd_en`, latch the operation, `addr` and `wr_data`, then go to LO.
  - If both `wr_en` and `rd_en` are high, the write wins.
- LO: hold for WAIT_CYCLES+1 cycles (4-bit counter), then go to HI.
- HI: hold for WAIT_CYCLES+1 cycles, then go to DONE.
- DONE: lasts one cycle, then goes unconditionally to IDLE, even if a request is still asserted.
- Write, during LO/HI:
  - `sram_dq_oe=1` and `sram_we_n=0`.
  - `sram_dq_out` = latched data [15:0] in LO, [31:16] in HI.
- Read, during LO/HI:
  - `sram_dq_oe=0` and `sram_we_n=1`.
  - `sram_dq_in` is sampled on the last cycle of LO into `rd_data[15:0]`, and on the last cycle of HI into `rd_data[31:16]`.
- `rd_data` is not changed by writes or by idle cycles.
- `ready`:
  - Combinational: `ready = (IDLE & !(wr_en|rd_en)) | DONE`.
  - It is low in the IDLE cycle that accepts a request.
- Once latched, an operation completes even if `wr_en`/`rd_en` drop mid-access.
- Outputs in IDLE and DONE: `sram_we_n=1`, `sram_dq_oe=0`. `sram_addr` and `sram_dq_out` hold their last value.

## Timing
- Reset values (`rst`=0 at a clock edge):
  - state IDLE, counter 0.
  - `rd_data=0`, `sram_addr=0`, `sram_dq_out=0`, `sram_dq_oe=0`, `sram_we_n=1`.
  - `ready` then follows the request inputs.
- Reset mid-access: state is IDLE on the next cycle. No further SRAM cycles occur and no partial `rd_data` update is made.
- Latency: with request cycle 0, the controller is in LO for cycles 1..W+1, in HI for cycles W+2..2W+2, and in DONE at cycle 2W+3 (ready=1).
  - Freeze length is 2W+3 cycles; W=1 gives `ready` low for cycles 0–4 and high in cycle 5.
- `rd_data` is valid in the DONE cycle and remains stable afterwards.
- Back-to-back requests: a new request is accepted in the IDLE cycle after DONE, so there is a minimum 1-cycle `ready` pulse between accesses.

## Configuration
- `SRAM_RANGE_CHECK_EN` defined:
  - An address outside [BASE_ADDR, BASE_ADDR+2^19) is not serviced: the FSM stays in IDLE, `ready` stays 1, there is no SRAM activity, and `rd_data` is unchanged.
- Undefined: no range check; out-of-range addresses wrap via the modulo-2^17 word index.

## Test plan
- Reset: hold `rst`=0 for 2 cycles, then release → `ready=1`, `sram_we_n=1`, `sram_dq_oe=0`, `rd_data=0`.
- Write, W=1, `addr`=1032, `wr_data`=0xDEADBEEF:
  - Cycles 1–2: `sram_addr=4`, `dq_out=0xBEEF`, `we_n=0`.
  - Cycles 3–4: `sram_addr=5`, `dq_out=0xDEAD`.
  - Cycle 5: `ready=1`.
- Read back `addr`=1032 against an SRAM model → `rd_data`=0xDEADBEEF in the DONE cycle, with `we_n=1` throughout.
- `rd_en`=`wr_en`=1, `addr`=1024, `wr_data`=0x12345678 → write performed; halfwords 0/1 hold 0x5678/0x1234; `rd_data` unchanged.
- Write in progress, `rst`=0 during HI → next cycle IDLE, `we_n=1`, `dq_oe=0`. A following read of the same word returns only the low half updated.
- `addr`=0x100:
  - With `SRAM_RANGE_CHECK_EN`: `ready` stays 1 and there is no `we_n` pulse.
  - Without it: access completes at `sram_addr={(0x100-1024)>>2 mod 2^17, h}` = {0x1FF40, h}.
